// File: rtl/branch_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_exec_unit_if
// Description : Issue, SPR/CR write and redirect bundle of the branch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_exec_unit_if #(
    parameter int ADDRESS_WIDTH      = 64,
    parameter int IMM_WIDTH          = 24,
    parameter int BD_WIDTH           = 14,
    parameter int OPCODE_WIDTH       = 6,
    parameter int XOPCODE_WIDTH      = 10,
    parameter int FORMAT_INDEX_RANGE = 5
);
    logic                          stall_i;
    logic                          enable_i;
    logic                          is64Bit_i;
    logic [FORMAT_INDEX_RANGE-1:0] instructionFormat_i;
    logic [OPCODE_WIDTH-1:0]       opCode_i;
    logic [XOPCODE_WIDTH-1:0]      xOpCode_i;
    logic [ADDRESS_WIDTH-1:0]      instructionAddress_i;
    logic [IMM_WIDTH-1:0]          imm_i;
    logic [BD_WIDTH-1:0]           bd_i;
    logic [4:0]                    bo_i;
    logic [4:0]                    bi_i;
    logic                          aa_i;
    logic                          lk_i;
    logic                          sprWrite_i;
    logic [1:0]                    sprSel_i;
    logic [ADDRESS_WIDTH-1:0]      sprData_i;
    logic                          crWrite_i;
    logic [7:0]                    crMask_i;
    logic [31:0]                   crData_i;

    logic                          valid_o;
    logic                          isBranching_o;
    logic [ADDRESS_WIDTH-1:0]      PC_o;
    logic                          illegal_o;
    logic [ADDRESS_WIDTH-1:0]      linkReg_o;
    logic [ADDRESS_WIDTH-1:0]      countReg_o;
    logic [31:0]                   conditionReg_o;

    modport master (
        output stall_i, enable_i, is64Bit_i, instructionFormat_i, opCode_i,
               xOpCode_i, instructionAddress_i, imm_i, bd_i, bo_i, bi_i,
               aa_i, lk_i, sprWrite_i, sprSel_i, sprData_i,
               crWrite_i, crMask_i, crData_i,
        input  valid_o, isBranching_o, PC_o, illegal_o,
               linkReg_o, countReg_o, conditionReg_o
    );

    modport slave (
        input  stall_i, enable_i, is64Bit_i, instructionFormat_i, opCode_i,
               xOpCode_i, instructionAddress_i, imm_i, bd_i, bo_i, bi_i,
               aa_i, lk_i, sprWrite_i, sprSel_i, sprData_i,
               crWrite_i, crMask_i, crData_i,
        output valid_o, isBranching_o, PC_o, illegal_o,
               linkReg_o, countReg_o, conditionReg_o
    );
endinterface
`default_nettype wire

// File: rtl/branch_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_exec_unit
// Description : Resolves I/B/XL-form branches, owns CR/LR/CTR/TAR and issues
//               a registered redirect one cycle after issue.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_exec_unit #(
    parameter int                       ADDRESS_WIDTH      = 64,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR       = '0,
    parameter int                       IMM_WIDTH          = 24,
    parameter int                       BD_WIDTH           = 14,
    parameter int                       OPCODE_WIDTH       = 6,
    parameter int                       XOPCODE_WIDTH      = 10,
    parameter int                       FORMAT_INDEX_RANGE = 5,
    parameter int                       B                  = 2,
    parameter int                       I                  = 7,
    parameter int                       XL                 = 18
) (
    input  wire logic         clock_i,
    input  wire logic         reset_i,
    branch_exec_unit_if.slave bus
);
    localparam logic [FORMAT_INDEX_RANGE-1:0] c_FMT_B  = FORMAT_INDEX_RANGE'(B);
    localparam logic [FORMAT_INDEX_RANGE-1:0] c_FMT_I  = FORMAT_INDEX_RANGE'(I);
    localparam logic [FORMAT_INDEX_RANGE-1:0] c_FMT_XL = FORMAT_INDEX_RANGE'(XL);
    localparam logic [OPCODE_WIDTH-1:0]       c_OP_B   = OPCODE_WIDTH'(16);
    localparam logic [OPCODE_WIDTH-1:0]       c_OP_I   = OPCODE_WIDTH'(18);
    localparam logic [OPCODE_WIDTH-1:0]       c_OP_XL  = OPCODE_WIDTH'(19);
    localparam logic [XOPCODE_WIDTH-1:0]      c_XOP_BCLR  = XOPCODE_WIDTH'(16);
    localparam logic [XOPCODE_WIDTH-1:0]      c_XOP_BCCTR = XOPCODE_WIDTH'(528);
    localparam logic [XOPCODE_WIDTH-1:0]      c_XOP_BCTAR = XOPCODE_WIDTH'(560);
    localparam logic [ADDRESS_WIDTH-1:0]      c_LOW32     = ADDRESS_WIDTH'(64'hFFFF_FFFF);
    localparam logic [ADDRESS_WIDTH-1:0]      c_WORD_MASK = ~ADDRESS_WIDTH'(3);

    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic                     r_valid;
    logic                     r_taken;
    logic                     r_illegal;
    logic [ADDRESS_WIDTH-1:0] r_lr;
    logic [ADDRESS_WIDTH-1:0] r_ctr;
    logic [ADDRESS_WIDTH-1:0] r_tar;
    logic [31:0]              r_cr;

    logic                     w_is_i;
    logic                     w_is_b;
    logic                     w_is_xl;
    logic                     w_xop_bclr;
    logic                     w_xop_bcctr;
    logic                     w_xop_bctar;
    logic                     w_xl_legal;
    logic [ADDRESS_WIDTH-1:0] w_seq_pc;
    logic [ADDRESS_WIDTH-1:0] w_li_ext;
    logic [ADDRESS_WIDTH-1:0] w_bd_ext;
    logic [ADDRESS_WIDTH-1:0] w_rel_base;
    logic [ADDRESS_WIDTH-1:0] w_xl_target;
    logic [ADDRESS_WIDTH-1:0] w_ctr_dec;
    logic [ADDRESS_WIDTH-1:0] w_ctr_m;
    logic [4:0]               w_cr_idx;
    logic                     w_ctr_ok;
    logic                     w_cond_ok;
    logic [ADDRESS_WIDTH-1:0] w_target;
    logic                     w_taken;
    logic                     w_illegal;
    logic                     w_ctr_dec_en;
    logic                     w_lr_link;
    logic [ADDRESS_WIDTH-1:0] w_next_pc;
    logic [ADDRESS_WIDTH-1:0] w_link_val;
    logic                     w_lr_upd;
    logic                     w_ctr_upd;
    logic [31:0]              w_cr_wmask;
    logic [31:0]              w_cr_next;

    // Instruction class decode
    assign w_is_i  = (bus.instructionFormat_i == c_FMT_I)  && (bus.opCode_i == c_OP_I);
    assign w_is_b  = (bus.instructionFormat_i == c_FMT_B)  && (bus.opCode_i == c_OP_B);
    assign w_is_xl = (bus.instructionFormat_i == c_FMT_XL) && (bus.opCode_i == c_OP_XL);

    assign w_xop_bclr  = (bus.xOpCode_i == c_XOP_BCLR);
    assign w_xop_bcctr = (bus.xOpCode_i == c_XOP_BCCTR);
    assign w_xop_bctar = (bus.xOpCode_i == c_XOP_BCTAR);
    assign w_xl_legal  = w_xop_bclr | w_xop_bcctr | w_xop_bctar;

    assign w_seq_pc   = bus.instructionAddress_i + ADDRESS_WIDTH'(4);
    assign w_li_ext   = {{(ADDRESS_WIDTH-IMM_WIDTH-2){bus.imm_i[IMM_WIDTH-1]}}, bus.imm_i, 2'b00};
    assign w_bd_ext   = {{(ADDRESS_WIDTH-BD_WIDTH-2){bus.bd_i[BD_WIDTH-1]}}, bus.bd_i, 2'b00};
    assign w_rel_base = bus.aa_i ? '0 : bus.instructionAddress_i;

    always_comb begin
        w_xl_target = r_lr;
        if (w_xop_bcctr) begin
            w_xl_target = r_ctr;
        end else if (w_xop_bctar) begin
            w_xl_target = r_tar;
        end
        w_xl_target = w_xl_target & c_WORD_MASK;
    end

    // BO is numbered MSB-first: BO[0]=bo_i[4] ... BO[3]=bo_i[1]
    assign w_ctr_dec = r_ctr - ADDRESS_WIDTH'(1);
    assign w_ctr_m   = bus.is64Bit_i ? w_ctr_dec : (w_ctr_dec & c_LOW32);
    assign w_ctr_ok  = bus.bo_i[2] | ((w_ctr_m != '0) ^ bus.bo_i[1]);
    assign w_cr_idx  = 5'd31 - bus.bi_i;
    assign w_cond_ok = bus.bo_i[4] | (r_cr[w_cr_idx] == bus.bo_i[3]);

    always_comb begin
        w_target     = w_seq_pc;
        w_taken      = 1'b0;
        w_illegal    = 1'b0;
        w_ctr_dec_en = 1'b0;
        w_lr_link    = 1'b0;
        if (w_is_i) begin
            w_target  = w_rel_base + w_li_ext;
            w_taken   = 1'b1;
            w_lr_link = bus.lk_i;
        end else if (w_is_b) begin
            w_target     = w_rel_base + w_bd_ext;
            w_taken      = w_ctr_ok & w_cond_ok;
            w_ctr_dec_en = ~bus.bo_i[2];
            w_lr_link    = bus.lk_i;
        end else if (w_is_xl) begin
            if (w_xl_legal) begin
                // bcctr cannot use CTR as both target and loop count
                w_target     = w_xl_target;
                w_taken      = (w_xop_bcctr | w_ctr_ok) & w_cond_ok;
                w_ctr_dec_en = ~bus.bo_i[2] & ~w_xop_bcctr;
                w_lr_link    = bus.lk_i;
            end else begin
                w_illegal = 1'b1;
            end
        end
    end

    assign w_next_pc  = bus.is64Bit_i ? (w_taken ? w_target : w_seq_pc)
                                      : ((w_taken ? w_target : w_seq_pc) & c_LOW32);
    assign w_link_val = bus.is64Bit_i ? w_seq_pc : (w_seq_pc & c_LOW32);
    assign w_lr_upd   = bus.enable_i & w_lr_link;
    assign w_ctr_upd  = bus.enable_i & w_ctr_dec_en;

    // CR field k (CR[32+4k : 35+4k]) maps to r_cr[31-4k -: 4], mask bit 7-k
    for (genvar g = 0; g < 8; g++) begin : g_cr_field
        assign w_cr_wmask[31-4*g -: 4] = {4{bus.crMask_i[7-g]}};
    end
    assign w_cr_next = (r_cr & ~w_cr_wmask) | (bus.crData_i & w_cr_wmask);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_pc      <= RESET_VECTOR;
            r_valid   <= 1'b0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
            r_lr      <= '0;
            r_ctr     <= '0;
            r_tar     <= '0;
            r_cr      <= '0;
        end else if (!bus.stall_i) begin
            r_valid   <= bus.enable_i;
            r_taken   <= bus.enable_i & w_taken;
            r_illegal <= bus.enable_i & w_illegal;
            if (bus.enable_i) begin
                r_pc <= w_next_pc;
            end
            // Branch-side LR/CTR updates take precedence over FX writes
            if (w_lr_upd) begin
                r_lr <= w_link_val;
            end else if (bus.sprWrite_i && bus.sprSel_i == 2'd0) begin
                r_lr <= bus.sprData_i;
            end
            if (w_ctr_upd) begin
                r_ctr <= w_ctr_dec;
            end else if (bus.sprWrite_i && bus.sprSel_i == 2'd1) begin
                r_ctr <= bus.sprData_i;
            end
            if (bus.sprWrite_i && bus.sprSel_i == 2'd2) begin
                r_tar <= bus.sprData_i;
            end
            if (bus.crWrite_i) begin
                r_cr <= w_cr_next;
            end
        end
    end

    assign bus.valid_o        = r_valid;
    assign bus.isBranching_o  = r_taken;
    assign bus.PC_o           = r_pc;
    assign bus.illegal_o      = r_illegal;
    assign bus.linkReg_o      = r_lr;
    assign bus.countReg_o     = r_ctr;
    assign bus.conditionReg_o = r_cr;

endmodule
`default_nettype wire

// File: tb/tb_branch_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_exec_unit
// Description : Scoreboard bench for branch_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_exec_unit;
    localparam logic [63:0] c_RV = 64'h0000_0000_0000_0100;

    typedef struct {
        logic        rst, stall, en, is64;
        logic [4:0]  fmt;
        logic [5:0]  op;
        logic [9:0]  xop;
        logic [63:0] addr;
        logic [23:0] imm;
        logic [13:0] bd;
        logic [4:0]  bo, bi;
        logic        aa, lk, sprw;
        logic [1:0]  sprsel;
        logic [63:0] sprdata;
        logic        crw;
        logic [7:0]  crmask;
        logic [31:0] crdata;
    } stim_t;

    typedef struct {
        logic [66:0]  res;
        logic [159:0] regs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;

    stim_t stq[$];
    exp_t  sb[$];
    logic [63:0] m_lr  = '0;
    logic [63:0] m_ctr = '0;
    logic [31:0] m_cr  = '0;

    branch_exec_unit_if bus ();
    branch_exec_unit #(.RESET_VECTOR(c_RV)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t f_idle();
        stim_t s;
        s = '{default: '0};
        s.is64 = 1'b1;
        return s;
    endfunction

    function automatic stim_t f_i(logic [63:0] addr, logic [23:0] imm, logic aa, logic lk);
        stim_t s = f_idle();
        s.en = 1'b1; s.fmt = 5'd7; s.op = 6'd18;
        s.addr = addr; s.imm = imm; s.aa = aa; s.lk = lk;
        return s;
    endfunction

    function automatic stim_t f_b(logic [63:0] addr, logic [13:0] bd, logic [4:0] bo,
                                  logic [4:0] bi, logic aa, logic lk);
        stim_t s = f_idle();
        s.en = 1'b1; s.fmt = 5'd2; s.op = 6'd16;
        s.addr = addr; s.bd = bd; s.bo = bo; s.bi = bi; s.aa = aa; s.lk = lk;
        return s;
    endfunction

    function automatic stim_t f_xl(logic [63:0] addr, logic [9:0] xop, logic [4:0] bo,
                                   logic [4:0] bi, logic lk);
        stim_t s = f_idle();
        s.en = 1'b1; s.fmt = 5'd18; s.op = 6'd19;
        s.addr = addr; s.xop = xop; s.bo = bo; s.bi = bi; s.lk = lk;
        return s;
    endfunction

    function automatic stim_t f_spr(stim_t base, logic [1:0] sel, logic [63:0] data);
        stim_t s = base;
        s.sprw = 1'b1; s.sprsel = sel; s.sprdata = data;
        return s;
    endfunction

    function automatic stim_t f_cr(stim_t base, logic [7:0] mask, logic [31:0] data);
        stim_t s = base;
        s.crw = 1'b1; s.crmask = mask; s.crdata = data;
        return s;
    endfunction

    // Queue a stimulus with the outputs and registers it must produce
    task automatic add(input stim_t s, input logic v, input logic t, input logic il,
                       input logic [63:0] pc);
        exp_t e;
        stq.push_back(s);
        e.res  = {v, t, il, pc};
        e.regs = {m_lr, m_ctr, m_cr};
        sb.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        rst                      = s.rst;
        bus.stall_i              = s.stall;
        bus.enable_i             = s.en;
        bus.is64Bit_i            = s.is64;
        bus.instructionFormat_i  = s.fmt;
        bus.opCode_i             = s.op;
        bus.xOpCode_i            = s.xop;
        bus.instructionAddress_i = s.addr;
        bus.imm_i                = s.imm;
        bus.bd_i                 = s.bd;
        bus.bo_i                 = s.bo;
        bus.bi_i                 = s.bi;
        bus.aa_i                 = s.aa;
        bus.lk_i                 = s.lk;
        bus.sprWrite_i           = s.sprw;
        bus.sprSel_i             = s.sprsel;
        bus.sprData_i            = s.sprdata;
        bus.crWrite_i            = s.crw;
        bus.crMask_i             = s.crmask;
        bus.crData_i             = s.crdata;
    endtask

    function automatic logic [66:0] obs_res();
        return {bus.valid_o, bus.isBranching_o, bus.illegal_o, bus.PC_o};
    endfunction

    function automatic logic [159:0] obs_regs();
        return {bus.linkReg_o, bus.countReg_o, bus.conditionReg_o};
    endfunction

    task automatic test_reset();
        exp_t  e;
        stim_t s;
        int    k = 0;
        s = f_idle(); s.rst = 1'b1;
        add(s, 0, 0, 0, c_RV);
        add(f_spr(s, 2'd0, 64'h55), 0, 0, 0, c_RV);
        s = f_i(64'h1000, 24'h10, 1'b0, 1'b1); s.rst = 1'b1; s.stall = 1'b1;
        add(s, 0, 0, 0, c_RV);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs_res() !== e.res) begin
                bad++;
                $display("FAIL reset[%0d] result: got %h required %h", k, obs_res(), e.res);
            end
            total++;
            if (obs_regs() !== e.regs) begin
                bad++;
                $display("FAIL reset[%0d] regs: got %h required %h", k, obs_regs(), e.regs);
            end
            k++;
        end
    endtask

    task automatic test_iform();
        exp_t e;
        int   k = 0;
        m_lr = 64'h1004;
        add(f_i(64'h1000, 24'h000010, 1'b0, 1'b1), 1, 1, 0, 64'h1040);
        add(f_idle(), 0, 0, 0, 64'h1040);
        begin
            stim_t s = f_i(64'h2000, 24'h10, 1'b0, 1'b1);
            s.op = 6'd16;
            add(s, 1, 0, 0, 64'h2004);
        end
        add(f_i(64'h5000, 24'h20, 1'b1, 1'b0), 1, 1, 0, 64'h80);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs_res() !== e.res) begin
                bad++;
                $display("FAIL iform[%0d] result: got %h required %h", k, obs_res(), e.res);
            end
            total++;
            if (obs_regs() !== e.regs) begin
                bad++;
                $display("FAIL iform[%0d] regs: got %h required %h", k, obs_regs(), e.regs);
            end
            k++;
        end
    endtask

    task automatic test_ctr_loop();
        exp_t e;
        int   k = 0;
        m_ctr = 64'd2;
        add(f_spr(f_idle(), 2'd1, 64'd2), 0, 0, 0, 64'h80);
        m_ctr = 64'd1;
        add(f_b(64'h200, 14'h3FFF, 5'b10000, 5'd0, 1'b0, 1'b0), 1, 1, 0, 64'h1FC);
        m_ctr = 64'd0;
        add(f_b(64'h200, 14'h3FFF, 5'b10000, 5'd0, 1'b0, 1'b0), 1, 0, 0, 64'h204);
        m_ctr = 64'hFFFF_FFFF_FFFF_FFFF;
        add(f_spr(f_b(64'h200, 14'h3FFF, 5'b10000, 5'd0, 1'b0, 1'b0), 2'd1, 64'd5),
            1, 1, 0, 64'h1FC);
        m_ctr = 64'hFFFF_FFFF_FFFF_FFFE;
        add(f_b(64'h200, 14'h3FFF, 5'b10010, 5'd0, 1'b0, 1'b0), 1, 0, 0, 64'h204);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs_res() !== e.res) begin
                bad++;
                $display("FAIL ctr_loop[%0d] result: got %h required %h", k, obs_res(), e.res);
            end
            total++;
            if (obs_regs() !== e.regs) begin
                bad++;
                $display("FAIL ctr_loop[%0d] regs: got %h required %h", k, obs_regs(), e.regs);
            end
            k++;
        end
    endtask

    task automatic test_cr_branch();
        exp_t e;
        int   k = 0;
        m_cr = 32'h2000_0000;
        add(f_cr(f_idle(), 8'h80, 32'h2000_0000), 0, 0, 0, 64'h204);
        add(f_b(64'h300, 14'h40, 5'b01100, 5'd2, 1'b1, 1'b0), 1, 1, 0, 64'h100);
        m_cr = 32'h2000_000F;
        add(f_cr(f_idle(), 8'h01, 32'hFFFF_FFFF), 0, 0, 0, 64'h100);
        add(f_b(64'h300, 14'h40, 5'b00100, 5'd2, 1'b1, 1'b0), 1, 0, 0, 64'h304);
        add(f_b(64'h300, 14'h40, 5'b00100, 5'd4, 1'b1, 1'b0), 1, 1, 0, 64'h100);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs_res() !== e.res) begin
                bad++;
                $display("FAIL cr_branch[%0d] result: got %h required %h", k, obs_res(), e.res);
            end
            total++;
            if (obs_regs() !== e.regs) begin
                bad++;
                $display("FAIL cr_branch[%0d] regs: got %h required %h", k, obs_regs(), e.regs);
            end
            k++;
        end
    endtask

    task automatic test_xl_targets();
        exp_t e;
        int   k = 0;
        m_lr = 64'h3003;
        add(f_spr(f_idle(), 2'd0, 64'h3003), 0, 0, 0, 64'h100);
        m_lr = 64'h504;
        add(f_spr(f_xl(64'h500, 10'd16, 5'b10100, 5'd0, 1'b1), 2'd0, 64'h9999),
            1, 1, 0, 64'h3000);
        m_ctr = 64'h7777;
        add(f_spr(f_idle(), 2'd1, 64'h7777), 0, 0, 0, 64'h3000);
        add(f_xl(64'h600, 10'd528, 5'b10100, 5'd0, 1'b0), 1, 1, 0, 64'h7774);
        add(f_spr(f_idle(), 2'd2, 64'h8002), 0, 0, 0, 64'h7774);
        add(f_xl(64'h700, 10'd560, 5'b10100, 5'd0, 1'b0), 1, 1, 0, 64'h8000);
        add(f_spr(f_idle(), 2'd3, 64'h1234), 0, 0, 0, 64'h8000);
        m_ctr = 64'h7776;
        add(f_xl(64'h800, 10'd16, 5'b10000, 5'd0, 1'b0), 1, 1, 0, 64'h504);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs_res() !== e.res) begin
                bad++;
                $display("FAIL xl[%0d] result: got %h required %h", k, obs_res(), e.res);
            end
            total++;
            if (obs_regs() !== e.regs) begin
                bad++;
                $display("FAIL xl[%0d] regs: got %h required %h", k, obs_regs(), e.regs);
            end
            k++;
        end
    endtask

    task automatic test_mode32();
        exp_t  e;
        stim_t s;
        int    k = 0;
        s = f_i(64'h40, 24'hFFFFFF, 1'b1, 1'b0); s.is64 = 1'b0;
        add(s, 1, 1, 0, 64'h0000_0000_FFFF_FFFC);
        m_ctr = 64'h1_0000_0001;
        s = f_spr(f_idle(), 2'd1, 64'h1_0000_0001); s.is64 = 1'b0;
        add(s, 0, 0, 0, 64'h0000_0000_FFFF_FFFC);
        m_ctr = 64'h1_0000_0000;
        s = f_b(64'h700, 14'h10, 5'b10000, 5'd0, 1'b0, 1'b0); s.is64 = 1'b0;
        add(s, 1, 0, 0, 64'h704);
        m_lr = 64'h2345_6004;
        s = f_i(64'h1_2345_6000, 24'h4, 1'b0, 1'b1); s.is64 = 1'b0;
        add(s, 1, 1, 0, 64'h2345_6010);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs_res() !== e.res) begin
                bad++;
                $display("FAIL mode32[%0d] result: got %h required %h", k, obs_res(), e.res);
            end
            total++;
            if (obs_regs() !== e.regs) begin
                bad++;
                $display("FAIL mode32[%0d] regs: got %h required %h", k, obs_regs(), e.regs);
            end
            k++;
        end
    endtask

    task automatic test_stall_reset();
        exp_t  e;
        stim_t s;
        int    k = 0;
        add(f_i(64'h1000, 24'h10, 1'b0, 1'b0), 1, 1, 0, 64'h1040);
        s = f_cr(f_spr(f_i(64'h4000, 24'h8, 1'b0, 1'b1), 2'd0, 64'hAAAA), 8'hFF, 32'h1234_5678);
        s.stall = 1'b1;
        add(s, 1, 1, 0, 64'h1040);
        s = f_idle(); s.stall = 1'b1;
        add(s, 1, 1, 0, 64'h1040);
        m_lr = '0; m_ctr = '0; m_cr = '0;
        s.rst = 1'b1;
        add(s, 0, 0, 0, c_RV);
        add(f_xl(64'h900, 10'd33, 5'b10000, 5'd0, 1'b1), 1, 0, 1, 64'h904);
        add(f_idle(), 0, 0, 0, 64'h904);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs_res() !== e.res) begin
                bad++;
                $display("FAIL stall_reset[%0d] result: got %h required %h", k, obs_res(), e.res);
            end
            total++;
            if (obs_regs() !== e.regs) begin
                bad++;
                $display("FAIL stall_reset[%0d] regs: got %h required %h", k, obs_regs(), e.regs);
            end
            k++;
        end
    endtask

    initial begin
        apply(f_idle());
        rst = 1'b1;
        test_reset();
        test_iform();
        test_ctr_loop();
        test_cr_branch();
        test_xl_targets();
        test_mode32();
        test_stall_reset();
        apply(f_idle());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
